reg8_write_port: RTL and testbench

Write side of the 8 x 32-bit register bank whose outputs R1..R8 feed the 3-bit-select 8:1 read mux in the single-cycle datapath. A write request (enable, 3-bit address, 32-bit data) is captured into a one-entry write-back buffer. It commits to the addressed register on the following clock edge through a 3-to-8 one-hot decoder. The buffered entry is exported so the read path can bypass it, and a wrapping counter tallies committed writes for debug.

---
 rtl/reg8_write_port.sv | 137 +++++++++++++
 tb/tb_reg8_write_port.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg8_write_port.sv
// -----------------------------------------------------------------------------
// reg8_write_port
//
// Write side of an 8 x WIDTH register bank. The bank outputs R1..R8 feed an
// external 3-bit-select 8:1 read mux.
//
// Each write request (we/wa/wd) is captured into a one-entry write-back
// buffer. On the next rising edge the buffered entry commits to the addressed
// register through a 3-to-8 one-hot decoder. A new request is captured on that
// same edge, so the design sustains one write per cycle with no stall.
//
// The buffered entry is exported on pend_*. A reader that needs the newest
// value compares its read select against pend_addr while pend_valid is high.
//
// Parameters
//   WIDTH    data width of every register and of wd
//   ZERO_R1  1: R1 is hard-wired to zero. Writes to address 0 are dropped and
//            are not counted.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   we          write request valid this cycle
//   wa          write address (0 -> R1 ... 7 -> R8)
//   wd          write data
//   R1..R8      committed register contents
//   pend_valid  write-back buffer holds an uncommitted write
//   pend_addr   address of the buffered write
//   pend_data   data of the buffered write
//   wr_count    committed writes, modulo 256
// -----------------------------------------------------------------------------
module reg8_write_port #(
  parameter int WIDTH   = 32,
  parameter bit ZERO_R1 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       wa,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [WIDTH-1:0] R8,
  output logic             pend_valid,
  output logic [2:0]       pend_addr,
  output logic [WIDTH-1:0] pend_data,
  output logic [7:0]       wr_count
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic             pend_valid_q, pend_valid_d;
  logic [2:0]       pend_addr_q,  pend_addr_d;
  logic [WIDTH-1:0] pend_data_q,  pend_data_d;
  logic [7:0]       wr_count_q,   wr_count_d;
  logic [7:0]       dec_en;

  // Stage 1: capture the request into the write-back buffer.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pend_valid_d = we;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    // Address and data only move on a real request. An undriven wa while
    // we is low therefore never reaches the buffer.
    if (we) begin
      pend_addr_d = wa;
      pend_data_d = wd;
    end
  end

  // Stage 2: one-hot decode of the buffered address. At most one enable bit
  // can be set, and only while the buffer is valid.
  always_comb begin
    dec_en = 8'd0;
    if (pend_valid_q) begin
      dec_en[pend_addr_q] = 1'b1;
    end
    // With a hard-wired R1, an address-0 commit enables nothing. The
    // wr_count increment below is taken from dec_en, so that commit is
    // not counted either.
    if (ZERO_R1) begin
      dec_en[0] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = dec_en[i] ? pend_data_q : regs_q[i];
    end
    wr_count_d = wr_count_q + {7'd0, |dec_en};
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // All flops, including the register bank, see the same pre-edge values.
  // NOTE: the register bank is reset along with the control flops, because
  // R1..R8 must read zero out of reset. A reset also drops any buffered write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 3'd0;
      pend_data_q  <= '0;
      wr_count_q   <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign R1         = regs_q[0];
  assign R2         = regs_q[1];
  assign R3         = regs_q[2];
  assign R4         = regs_q[3];
  assign R5         = regs_q[4];
  assign R6         = regs_q[5];
  assign R7         = regs_q[6];
  assign R8         = regs_q[7];
  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_reg8_write_port.sv
// -----------------------------------------------------------------------------
// tb_reg8_write_port
//
// Directed bench for reg8_write_port. It drives two instances from the same
// stimulus:
//   dut  : ZERO_R1 = 0
//   dutz : ZERO_R1 = 1
//
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Every expected value below is computed by hand.
// -----------------------------------------------------------------------------
module tb_reg8_write_port;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we;
  logic [2:0]   wa;
  logic [W-1:0] wd;

  logic [W-1:0] r  [8];
  logic [W-1:0] rz [8];
  logic         pv, pvz;
  logic [2:0]   pa, paz;
  logic [W-1:0] pd, pdz;
  logic [7:0]   cnt, cntz;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg8_write_port #(.WIDTH(W), .ZERO_R1(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .R1(r[0]), .R2(r[1]), .R3(r[2]), .R4(r[3]),
    .R5(r[4]), .R6(r[5]), .R7(r[6]), .R8(r[7]),
    .pend_valid(pv), .pend_addr(pa), .pend_data(pd), .wr_count(cnt)
  );

  reg8_write_port #(.WIDTH(W), .ZERO_R1(1'b1)) dutz (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .R1(rz[0]), .R2(rz[1]), .R3(rz[2]), .R4(rz[3]),
    .R5(rz[4]), .R6(rz[5]), .R7(rz[6]), .R8(rz[7]),
    .pend_valid(pvz), .pend_addr(paz), .pend_data(pdz), .wr_count(cntz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive reset low in the middle of a cycle. All outputs must clear with
  // no clock edge in between.
  task automatic test_reset();
    rst_n = 1'b1; we = 1'b0; wa = 3'd0; wd = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (r[i] !== '0 || rz[i] !== '0) begin
        n_bad++;
        $display("FAIL reset_R%0d: got %h/%h expected 0", i + 1, r[i], rz[i]);
      end
    end
    n_vec++;
    if (pv !== 1'b0 || pa !== 3'd0 || pd !== '0 || cnt !== 8'd0 || cntz !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: pv=%b pa=%0d pd=%h cnt=%0d cntz=%0d expected all 0",
               pv, pa, pd, cnt, cntz);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    we = 1'b1; wa = 3'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; wa = 'x;
    n_vec++;
    if (pv !== 1'b1 || pa !== 3'd5 || pd !== 32'hDEADBEEF || r[5] !== '0) begin
      n_bad++;
      $display("FAIL single_capture: pv=%b pa=%0d pd=%h R6=%h expected 1/5/deadbeef/0",
               pv, pa, pd, r[5]);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (r[i] !== ((i == 5) ? 32'hDEADBEEF : 32'h0)) begin
        n_bad++;
        $display("FAIL single_R%0d: got %h", i + 1, r[i]);
      end
    end
    n_vec++;
    if (pv !== 1'b0 || pa !== 3'd5 || cnt !== 8'd1 || cntz !== 8'd1) begin
      n_bad++;
      $display("FAIL single_commit: pv=%b pa=%0d cnt=%0d cntz=%0d expected 0/5/1/1",
               pv, pa, cnt, cntz);
    end
    wa = 3'd0;
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wa = 3'd2; wd = 32'h11;
    tick();
    wd = 32'h22;
    tick();
    we = 1'b0;
    n_vec++;
    if (r[2] !== 32'h11 || pv !== 1'b1 || pd !== 32'h22) begin
      n_bad++;
      $display("FAIL b2b_first: R3=%h pv=%b pd=%h expected 11/1/22", r[2], pv, pd);
    end
    tick();
    n_vec++;
    if (r[2] !== 32'h22 || cnt !== 8'd3 || pv !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: R3=%h cnt=%0d pv=%b expected 22/3/0", r[2], cnt, pv);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); wd = 32'h100 + 32'(i);
      tick();
      n_vec++;
      if (pv !== 1'b1 || pvz !== 1'b1 || pa !== 3'(i)) begin
        n_bad++;
        $display("FAIL sweep_pend%0d: pv=%b pvz=%b pa=%0d", i, pv, pvz, pa);
      end
    end
    we = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (r[i] !== 32'h100 + 32'(i)) begin
        n_bad++;
        $display("FAIL sweep_R%0d: got %h expected %h", i + 1, r[i], 32'h100 + 32'(i));
      end
    end
    n_vec++;
    if (cnt !== 8'd11 || cntz !== 8'd10 || rz[0] !== '0 || pv !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_end: cnt=%0d cntz=%0d Rz1=%h pv=%b expected 11/10/0/0",
               cnt, cntz, rz[0], pv);
    end
  endtask

  task automatic test_zero_r1();
    we = 1'b1; wa = 3'd0; wd = 32'hFFFFFFFF;
    tick();
    we = 1'b0;
    n_vec++;
    if (pvz !== 1'b1 || pdz !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL zero_capture: pvz=%b pdz=%h expected 1/ffffffff", pvz, pdz);
    end
    tick();
    n_vec++;
    if (rz[0] !== '0 || cntz !== 8'd10 || pvz !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_commit: Rz1=%h cntz=%0d pvz=%b expected 0/10/0", rz[0], cntz, pvz);
    end
    n_vec++;
    if (r[0] !== 32'hFFFFFFFF || cnt !== 8'd12) begin
      n_bad++;
      $display("FAIL zero_normal: R1=%h cnt=%0d expected ffffffff/12", r[0], cnt);
    end
  endtask

  task automatic test_wrap_abort();
    // 244 more commits take dut from 12 to 256 = 0 and dutz from 10 to 254.
    for (int i = 0; i < 244; i++) begin
      we = 1'b1; wa = 3'd3; wd = 32'(i);
      tick();
    end
    we = 1'b0;
    n_vec++;
    if (cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL wrap_pre: cnt=%0d expected 255", cnt);
    end
    tick();
    n_vec++;
    if (cnt !== 8'd0 || cntz !== 8'd254 || r[3] !== 32'd243) begin
      n_bad++;
      $display("FAIL wrap: cnt=%0d cntz=%0d R4=%h expected 0/254/f3", cnt, cntz, r[3]);
    end
    // Capture a write, then reset before its commit edge.
    we = 1'b1; wa = 3'd7; wd = 32'hA5;
    tick();
    we = 1'b0;
    n_vec++;
    if (pv !== 1'b1 || pd !== 32'hA5) begin
      n_bad++;
      $display("FAIL abort_capture: pv=%b pd=%h expected 1/a5", pv, pd);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (pv !== 1'b0 || r[7] !== '0 || r[3] !== '0 || cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_inreset: pv=%b R8=%h R4=%h cnt=%0d expected 0", pv, r[7], r[3], cnt);
    end
    #2 rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (pv !== 1'b0 || r[7] !== '0 || cnt !== 8'd0 || cntz !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_release: pv=%b R8=%h cnt=%0d cntz=%0d expected 0", pv, r[7], cnt, cntz);
    end
  endtask

  // The first edge after reset release can capture a write, and the
  // earliest commit is on the edge after that.
  task automatic test_after_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    we = 1'b1; wa = 3'd1; wd = 32'h77;
    tick();
    we = 1'b0;
    n_vec++;
    if (pv !== 1'b1 || r[1] !== '0) begin
      n_bad++;
      $display("FAIL release_capture: pv=%b R2=%h expected 1/0", pv, r[1]);
    end
    tick();
    n_vec++;
    if (r[1] !== 32'h77 || cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL release_commit: R2=%h cnt=%0d expected 77/1", r[1], cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep();
    test_zero_r1();
    test_wrap_abort();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
